// File: rtl/jtframe_pocket_cmd.sv
// Bridge-mapped command block for the Pocket: decodes CMD/PARAM writes at 0xF8001000..08
// and sequences core reset release and data-slot loads, reporting status on read-back.
module jtframe_pocket_cmd #(
    parameter logic [15:0] TOUT = 16'hFFFF
) (
    input  logic        clk_74a,
    input  logic        reset_n,
    input  logic [31:0] bridge_addr,
    input  logic        bridge_rd,
    input  logic        bridge_wr,
    input  logic [31:0] bridge_wr_data,
    output logic [31:0] cmd_bridge_rd_data,
    output logic        core_rst,
    output logic        ds_req,
    output logic [15:0] ds_slot,
    output logic [31:0] ds_size,
    input  logic        ds_ack,
    input  logic        ds_err,
    output logic        all_done,
    output logic        busy
);
    localparam logic [31:0] ADDR_CMD  = 32'hF800_1000;
    localparam logic [31:0] ADDR_P0   = 32'hF800_1004;
    localparam logic [31:0] ADDR_P1   = 32'hF800_1008;
    localparam logic [15:0] CMD_KEY   = 16'h434D;
    localparam logic [15:0] SIG_BUSY  = 16'h4255;
    localparam logic [15:0] SIG_OK    = 16'h4F4B;
    localparam logic [15:0] SIG_ERR   = 16'h4552;
    localparam logic [15:0] OP_STATUS = 16'h0000;
    localparam logic [15:0] OP_RST_IN = 16'h0010;
    localparam logic [15:0] OP_RST_EX = 16'h0011;
    localparam logic [15:0] OP_SLOT   = 16'h0080;
    localparam logic [15:0] OP_DONE   = 16'h008F;
    localparam logic [15:0] HOLD_LAST = 16'd15;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DECODE   = 3'd1,
        RST_HOLD = 3'd2,
        DS_WAIT  = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [15:0] r_opcode, w_opcode_nxt;
    logic [15:0] r_sig, w_sig_nxt;
    logic        r_overrun, w_overrun_nxt;
    logic        r_ok, w_ok_nxt;
    logic [31:0] r_param0, w_param0_nxt;
    logic [31:0] r_param1, w_param1_nxt;
    logic        r_core_rst, w_core_rst_nxt;
    logic        r_all_done, w_all_done_nxt;
    logic        r_ds_req, w_ds_req_nxt;
    logic [15:0] r_ds_slot, w_ds_slot_nxt;
    logic [31:0] r_ds_size, w_ds_size_nxt;
    logic        r_busy;
    logic [31:0] r_rd_data, w_rd_val;
    logic        w_cmd_valid, w_p0_wr, w_p1_wr, w_rd_hit;

    assign w_cmd_valid = bridge_wr && (bridge_addr == ADDR_CMD) && (bridge_wr_data[31:16] == CMD_KEY);
    assign w_p0_wr     = bridge_wr && (bridge_addr == ADDR_P0);
    assign w_p1_wr     = bridge_wr && (bridge_addr == ADDR_P1);
    assign w_rd_hit    = bridge_rd && (bridge_addr[31:24] == 8'hF8);

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_opcode_nxt   = r_opcode;
        w_sig_nxt      = r_sig;
        w_overrun_nxt  = r_overrun;
        w_ok_nxt       = r_ok;
        w_param0_nxt   = r_param0;
        w_param1_nxt   = r_param1;
        w_core_rst_nxt = r_core_rst;
        w_all_done_nxt = r_all_done;
        w_ds_req_nxt   = 1'b0;
        w_ds_slot_nxt  = r_ds_slot;
        w_ds_size_nxt  = r_ds_size;

        case (r_state)
            IDLE: begin
                if (w_cmd_valid) begin
                    w_state_nxt   = DECODE;
                    w_opcode_nxt  = bridge_wr_data[15:0];
                    w_sig_nxt     = SIG_BUSY;
                    w_overrun_nxt = 1'b0;
                end
                if (w_p0_wr) w_param0_nxt = bridge_wr_data;
                if (w_p1_wr) w_param1_nxt = bridge_wr_data;
            end
            DECODE: begin
                w_state_nxt = RESP;
                w_ok_nxt    = 1'b1;
                case (r_opcode)
                    OP_STATUS: ;
                    OP_RST_IN: begin
                        w_core_rst_nxt = 1'b1;
                        w_all_done_nxt = 1'b0;
                    end
                    OP_RST_EX: begin
                        w_state_nxt = RST_HOLD;
                        w_cnt_nxt   = '0;
                    end
                    OP_SLOT: begin
                        w_ds_slot_nxt = r_param0[15:0];
                        w_ds_size_nxt = r_param1;
                        w_ds_req_nxt  = 1'b1;
                        w_state_nxt   = DS_WAIT;
                        w_cnt_nxt     = '0;
                    end
                    OP_DONE: w_all_done_nxt = 1'b1;
                    default: w_ok_nxt = 1'b0;
                endcase
            end
            RST_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_core_rst_nxt = 1'b0;
                    w_ok_nxt       = 1'b1;
                    w_state_nxt    = RESP;
                end else begin
                    w_cnt_nxt = 16'(r_cnt + 16'd1);
                end
            end
            DS_WAIT: begin
                // Acknowledge is checked first so it wins over a simultaneous timeout
                if (ds_ack) begin
                    w_ok_nxt    = !ds_err;
                    w_state_nxt = RESP;
                end else if (16'(r_cnt + 16'd1) == TOUT) begin
                    w_ok_nxt    = 1'b0;
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = 16'(r_cnt + 16'd1);
                end
            end
            RESP: begin
                w_sig_nxt   = r_ok ? SIG_OK : SIG_ERR;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_cmd_valid && (r_state != IDLE)) w_overrun_nxt = 1'b1;
    end

    // Read-back mux for the 0xF8 window
    always_comb begin
        w_rd_val = '0;
        case (bridge_addr)
            ADDR_CMD: w_rd_val = {r_sig, r_overrun, r_opcode[14:0]};
            ADDR_P0:  w_rd_val = r_param0;
            ADDR_P1:  w_rd_val = r_param1;
            default:  w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_opcode   <= '0;
            r_sig      <= SIG_OK;
            r_overrun  <= 1'b0;
            r_ok       <= 1'b1;
            r_param0   <= '0;
            r_param1   <= '0;
            r_core_rst <= 1'b1;
            r_all_done <= 1'b0;
            r_ds_req   <= 1'b0;
            r_ds_slot  <= '0;
            r_ds_size  <= '0;
            r_busy     <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_opcode   <= w_opcode_nxt;
            r_sig      <= w_sig_nxt;
            r_overrun  <= w_overrun_nxt;
            r_ok       <= w_ok_nxt;
            r_param0   <= w_param0_nxt;
            r_param1   <= w_param1_nxt;
            r_core_rst <= w_core_rst_nxt;
            r_all_done <= w_all_done_nxt;
            r_ds_req   <= w_ds_req_nxt;
            r_ds_slot  <= w_ds_slot_nxt;
            r_ds_size  <= w_ds_size_nxt;
            r_busy     <= (w_state_nxt != IDLE);
            if (w_rd_hit) r_rd_data <= w_rd_val;
        end
    end

    assign cmd_bridge_rd_data = r_rd_data;
    assign core_rst           = r_core_rst;
    assign ds_req             = r_ds_req;
    assign ds_slot            = r_ds_slot;
    assign ds_size            = r_ds_size;
    assign all_done           = r_all_done;
    assign busy               = r_busy;

endmodule

// File: doc/jtframe_pocket_cmd.md
JTFRAME_POCKET_CMD -- requirements
Module: jtframe_pocket_cmd

Interface
REQ-001 SHALL have ports: clk_74a  in  1  bridge clock; all logic runs in this single domain.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: bridge_addr  in  32; bridge_rd  in  1; bridge_wr  in  1; bridge_wr_data  in  32; big-endian bridge bus.
REQ-004 SHALL have ports: cmd_bridge_rd_data  out  32  registered read data for 0xF8xxxxxx.
REQ-005 SHALL have ports: core_rst  out  1  active-high core reset; ds_req  out  1  one-cycle data-slot request pulse; ds_slot  out  16; ds_size  out  32; ds_ack  in  1  slot load finished; ds_err  in  1  slot load failed, valid with ds_ack; all_done  out  1  level; busy  out  1.
REQ-006 SHALL have parameter: TOUT, default 16'hFFFF, data-slot acknowledge timeout in clocks.

Function
REQ-007 Register map: 0xF8001000 command/status (CMD); 0xF8001004 PARAM0; 0xF8001008 PARAM1; all other 0xF8xxxxxx addresses read 0 and ignore writes.
REQ-008 A write to CMD SHALL start a command only if bridge_wr_data[31:16]==16'h434D and state is IDLE; otherwise the write is dropped.
REQ-009 A valid CMD write in a busy state SHALL set sticky overrun flag (status bit, see REQ-011), cleared only by the next accepted command.
REQ-010 PARAM0/PARAM1 writes SHALL be accepted only in IDLE; dropped otherwise.
REQ-011 CMD read value: [31:16] signature (16'h4255 busy, 16'h4F4B ok, 16'h4552 error), [15] overrun, [14:0] last opcode[14:0]; PARAM reads return stored values.
REQ-012 cmd_bridge_rd_data SHALL update on the clock edge after bridge_rd is sampled high and hold until the next read.
REQ-013 States: IDLE, DECODE, RST_HOLD, DS_WAIT, RESP; busy=1 in every state except IDLE.
REQ-014 IDLE->DECODE on accepted CMD write; opcode latched, signature becomes 16'h4255 the same edge.
REQ-015 DECODE, opcode 0x0000 (status): result ok, ->RESP.
REQ-016 DECODE, opcode 0x0010 (reset enter): core_rst=1, all_done=0, ok, ->RESP.
REQ-017 DECODE, opcode 0x0011 (reset exit): ->RST_HOLD; after exactly 16 clocks core_rst=0, ok, ->RESP.
REQ-018 DECODE, opcode 0x0080 (slot load): ds_slot=PARAM0[15:0], ds_size=PARAM1, ds_req pulses one cycle, ->DS_WAIT with 16-bit counter cleared.
REQ-019 DS_WAIT: ds_ack=1 -> ok if ds_err=0 else error, ->RESP; counter reaching TOUT without ack -> error, ->RESP; ack and timeout in the same cycle -> ack wins.
REQ-020 DECODE, opcode 0x008F (all complete): all_done=1, ok, ->RESP.
REQ-021 Any other opcode: error, ->RESP, no output changes.
REQ-022 RESP: signature written, ->IDLE next cycle; total latency from CMD write to ok/error visible: 3 clocks for immediate opcodes, 19 for reset exit.
REQ-023 ds_ack outside DS_WAIT SHALL be ignored.

Reset
REQ-024 On reset_n low, asynchronously: state IDLE, core_rst=1, ds_req=0, ds_slot=0, ds_size=0, all_done=0, busy=0, PARAM0/1=0, overrun=0, status={16'h4F4B,1'b0,15'h0}, cmd_bridge_rd_data=0.
REQ-025 Reset mid-command SHALL abort it with no ds_req pulse after release; a CMD write is required to leave reset.

Verification
REQ-026 Write 0x434D0011 to 0xF8001000 after reset -> core_rst falls 17 clocks after the write; CMD read returns 0x4F4B0011.
REQ-027 PARAM0=0x0003, PARAM1=0x00020000, CMD=0x434D0080 -> one-cycle ds_req, ds_slot=3, ds_size=0x20000; ds_ack with ds_err=0 -> CMD reads 0x4F4B0080.
REQ-028 Slot load with ds_ack never asserted, TOUT=16 -> error after 16 clocks in DS_WAIT; CMD reads 0x45520080.
REQ-029 Second valid CMD write during DS_WAIT -> dropped, bit 15 set on read; next accepted command clears it.
REQ-030 CMD write 0x12340010 (bad signature) -> ignored, busy stays 0, core_rst unchanged; opcode 0x0055 -> CMD reads 0x45520055.
REQ-031 reset_n asserted during RST_HOLD -> core_rst=1 immediately, state IDLE, no further output activity until a new command.
